// File: rtl/interrupt_source_controller.sv
// interrupt_source_controller: drives RES_N, NMI_N and IRQ_N for a 6502-style CPU and acknowledges sources.
// Define VECTOR_OVERRIDE_EN to supply per-source IRQ vectors on FFFE/FFFF fetches.
module interrupt_source_controller #(
    parameter int         NUM_SRC     = 8,
    parameter int         RES_HOLD    = 8,
    parameter int         NMI_PULSE   = 2,
    parameter logic [7:0] VEC_BASE_LO = 8'h00,
    parameter logic [7:0] VEC_BASE_HI = 8'hF0
) (
    input  logic               clk_2,
    input  logic               res_p,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               nmi_req,
    input  logic               soft_reset_req,
    input  logic [15:0]        addr,
    input  logic               rw,
    output logic               RES_N,
    output logic               NMI_N,
    output logic               IRQ_N,
    output logic [NUM_SRC-1:0] irq_pending,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic [2:0]         active_src,
    output logic               vec_override,
    output logic [7:0]         vec_data
);

    localparam int RCW = $clog2(RES_HOLD + 1);
    localparam int NCW = $clog2(NMI_PULSE + 1);
    localparam logic [RCW-1:0] RES_LAST = RCW'(RES_HOLD - 1);
    localparam logic [NCW-1:0] NMI_LAST = NCW'(NMI_PULSE - 1);

    typedef enum logic {RS_HOLD, RS_RUN} rst_state_e;
    typedef enum logic [1:0] {NS_IDLE, NS_LOW, NS_WAIT} nmi_state_e;

    rst_state_e         rst_q, rst_d;
    logic [RCW-1:0]     rcnt_q, rcnt_d;
    nmi_state_e         nmi_q, nmi_d;
    logic [NCW-1:0]     ncnt_q, ncnt_d;
    logic               npend_q, npend_d;
    logic               nreq_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic [2:0]         act_q, act_d;

    logic [2:0] enc;
    logic       any_pend;
    logic       fetch_lo;
    logic       fetch_nmi;
    logic       nreq_edge;
    logic       nmi_start;

    assign irq_pending = irq_src & ~mask_q;
    assign any_pend    = |irq_pending;
    assign RES_N       = (rst_q == RS_RUN);
    assign NMI_N       = (nmi_q != NS_LOW);
    assign IRQ_N       = ~any_pend;
    assign irq_ack     = ack_q;
    assign active_src  = act_q;
    assign fetch_lo    = RES_N & rw & (addr == 16'hFFFE);
    assign fetch_nmi   = RES_N & rw & (addr == 16'hFFFA);
    assign nreq_edge   = nmi_req & ~nreq_q;

    // Lowest set index wins.
    always_comb begin
        enc = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (irq_pending[i]) enc = 3'(i);
        end
    end

    always_comb begin
        rst_d  = rst_q;
        rcnt_d = rcnt_q;
        if (soft_reset_req) begin
            rst_d  = RS_HOLD;
            rcnt_d = '0;
        end else if (rst_q == RS_HOLD) begin
            if (rcnt_q == RES_LAST) rst_d = RS_RUN;
            else rcnt_d = rcnt_q + RCW'(1);
        end
    end

    // A soft reset cycle never acknowledges: RES_N drops on the next edge.
    always_comb begin
        ack_d = '0;
        act_d = act_q;
        if (fetch_lo && any_pend && !soft_reset_req) begin
            ack_d = NUM_SRC'(1) << enc;
            act_d = enc;
        end
    end

    // ncnt counts pulse length in LOW and post-acknowledge high time in IDLE.
    always_comb begin
        nmi_d     = nmi_q;
        ncnt_d    = ncnt_q;
        nmi_start = 1'b0;
        unique case (nmi_q)
            NS_IDLE: begin
                if (npend_q && ncnt_q >= NMI_LAST) begin
                    nmi_d     = NS_LOW;
                    ncnt_d    = '0;
                    nmi_start = 1'b1;
                end else if (ncnt_q < NMI_LAST) begin
                    ncnt_d = ncnt_q + NCW'(1);
                end
            end
            NS_LOW: begin
                if (ncnt_q == NMI_LAST) begin
                    nmi_d  = NS_WAIT;
                    ncnt_d = '0;
                end else begin
                    ncnt_d = ncnt_q + NCW'(1);
                end
            end
            NS_WAIT: begin
                if (fetch_nmi) begin
                    nmi_d  = NS_IDLE;
                    ncnt_d = '0;
                end
            end
            default: nmi_d = NS_IDLE;
        endcase
        npend_d = (npend_q & ~nmi_start) | (nreq_edge & RES_N);
        if (soft_reset_req) begin
            nmi_d   = NS_IDLE;
            ncnt_d  = NMI_LAST;
            npend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_2) begin
        if (res_p) begin
            rst_q   <= RS_HOLD;
            rcnt_q  <= '0;
            nmi_q   <= NS_IDLE;
            ncnt_q  <= NMI_LAST;
            npend_q <= 1'b0;
            nreq_q  <= 1'b0;
            mask_q  <= '1;
            ack_q   <= '0;
            act_q   <= '0;
        end else begin
            rst_q   <= rst_d;
            rcnt_q  <= rcnt_d;
            nmi_q   <= nmi_d;
            ncnt_q  <= ncnt_d;
            npend_q <= npend_d;
            nreq_q  <= nmi_req;
            ack_q   <= ack_d;
            act_q   <= act_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

`ifdef VECTOR_OVERRIDE_EN
    always_comb begin
        vec_override = 1'b0;
        vec_data     = 8'h00;
        if (fetch_lo && any_pend) begin
            vec_override = 1'b1;
            vec_data     = VEC_BASE_LO + {4'b0000, enc, 1'b0};
        end else if (RES_N && rw && addr == 16'hFFFF && |ack_q) begin
            vec_override = 1'b1;
            vec_data     = VEC_BASE_HI;
        end
    end
`else
    assign vec_override = 1'b0;
    assign vec_data     = 8'h00;
`endif

endmodule
